// File: rtl/controle_busca_instrucao.sv
// Instruction-memory port owner: byte-serial loader, PC sequencing, stall/branch redirects, run/halt status.
// Optional feature: define HALT_ON_ECALL_EN to stop in PARADO on a fetched ecall/ebreak.
module controle_busca_instrucao #(
    parameter int          NUM_PALAVRAS = 256,
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Start_Carga,
    input  logic              Fim_Carga,
    input  logic              Byte_Valido,
    input  logic [7:0]        Byte_Dado,
    output logic              Byte_Pronto,
    input  logic              Iniciar,
    input  logic              Stall,
    input  logic              Desvio,
    input  logic [31:0]       Alvo_Desvio,
    input  logic [31:0]       Instrucao_In,
    output logic [ADDR_W-1:0] Mem_Endereco,
    output logic              Mem_Escrita,
    output logic [31:0]       Mem_Dado,
    output logic [31:0]       PC,
    output logic              Instrucao_Valida,
    output logic              Executando,
    output logic [ADDR_W:0]   Palavras_Carregadas,
    output logic              Erro_Alinhamento
);
    localparam int                PC_W       = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] ULTIMO     = ADDR_W'(NUM_PALAVRAS - 1);
    localparam logic [PC_W-1:0]   PC_INICIAL = RESET_PC[PC_W-1:0];
`ifdef HALT_ON_ECALL_EN
    localparam logic PARA_EM_ECALL = 1'b1;
`else
    localparam logic PARA_EM_ECALL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CARGA, EXECUTA, PARADO} estado_t;

    estado_t           estado, estado_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0] ponteiro, ponteiro_d;
    logic [1:0]        lane, lane_d;
    logic [31:0]       palavra, palavra_d;
    logic              escrita, escrita_d;
    logic              encerrar, encerrar_d;
    logic [ADDR_W:0]   palavras, palavras_d;
    logic              erro, erro_d;
    logic              ecall_detectado;
    logic              unused_alvo;

    // The PC lives modulo the memory size, so the upper target bits are dropped.
    assign unused_alvo     = ^Alvo_Desvio[31:PC_W];
    assign ecall_detectado = PARA_EM_ECALL &&
                             (Instrucao_In == 32'h00000073 || Instrucao_In == 32'h00100073);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= IDLE;
            pc_q     <= PC_INICIAL;
            ponteiro <= '0;
            lane     <= '0;
            palavra  <= '0;
            escrita  <= 1'b0;
            encerrar <= 1'b0;
            palavras <= '0;
            erro     <= 1'b0;
        end else begin
            estado   <= estado_d;
            pc_q     <= pc_d;
            ponteiro <= ponteiro_d;
            lane     <= lane_d;
            palavra  <= palavra_d;
            escrita  <= escrita_d;
            encerrar <= encerrar_d;
            palavras <= palavras_d;
            erro     <= erro_d;
        end
    end

    always_comb begin
        estado_d   = estado;
        pc_d       = pc_q;
        ponteiro_d = ponteiro;
        lane_d     = lane;
        palavra_d  = palavra;
        escrita_d  = 1'b0;
        encerrar_d = encerrar;
        palavras_d = palavras;
        erro_d     = erro;
        if (Start_Carga) begin
            estado_d   = CARGA;
            ponteiro_d = '0;
            lane_d     = '0;
            palavra_d  = '0;
            encerrar_d = 1'b0;
            palavras_d = '0;
            erro_d     = 1'b0;
        end else begin
            case (estado)
                IDLE, PARADO: begin
                    if (Iniciar) begin
                        estado_d = EXECUTA;
                        pc_d     = PC_INICIAL;
                        erro_d   = 1'b0;
                    end
                end
                CARGA: begin
                    if (escrita) begin
                        ponteiro_d = ponteiro + 1'b1;
                        palavras_d = palavras + 1'b1;
                        palavra_d  = '0;
                        lane_d     = '0;
                        encerrar_d = 1'b0;
                        if (encerrar || Fim_Carga || ponteiro == ULTIMO)
                            estado_d = IDLE;
                    end else begin
                        if (Byte_Valido) begin
                            palavra_d[{lane, 3'b000} +: 8] = Byte_Dado;
                            lane_d = lane + 1'b1;
                            if (lane == 2'd3)
                                escrita_d = 1'b1;
                        end
                        // A byte arriving with Fim_Carga is kept, then the partial word is flushed.
                        if (Fim_Carga) begin
                            if (Byte_Valido || lane != 2'd0) begin
                                escrita_d  = 1'b1;
                                encerrar_d = 1'b1;
                            end else begin
                                estado_d = IDLE;
                            end
                        end
                    end
                end
                EXECUTA: begin
                    if (!Stall) begin
                        if (ecall_detectado) begin
                            estado_d = PARADO;
                        end else if (Desvio) begin
                            if (Alvo_Desvio[1:0] != 2'b00) begin
                                erro_d   = 1'b1;
                                estado_d = PARADO;
                            end else begin
                                pc_d = Alvo_Desvio[PC_W-1:0];
                            end
                        end else begin
                            pc_d = pc_q + PC_W'(4);
                        end
                    end
                end
                default: estado_d = IDLE;
            endcase
        end
    end

    assign Byte_Pronto         = (estado == CARGA) && !escrita;
    assign Mem_Escrita         = escrita;
    assign Mem_Dado            = escrita ? palavra : 32'h0;
    assign Mem_Endereco        = (estado == CARGA) ? ponteiro : pc_q[PC_W-1:2];
    assign PC                  = {{(32-PC_W){1'b0}}, pc_q};
    assign Executando          = (estado == EXECUTA);
    assign Instrucao_Valida    = (estado == EXECUTA) && !Stall;
    assign Palavras_Carregadas = palavras;
    assign Erro_Alinhamento    = erro;

endmodule

// File: doc/controle_busca_instrucao.md
Name: controle_busca_instrucao

Overview:
Sequencer and owner of the instruction memory port. Arbitrates the single 256-word instruction memory between a byte-serial program loader, which writes words, and the fetch path, which reads at the PC. Holds the architectural PC, applies stall and branch redirects, and reports run/halt status to the rest of the RISC-V datapath.

Parameters:
NUM_PALAVRAS, 256, instruction memory depth in 32-bit words (power of 2).
ADDR_W, 8, word-index width, equal to log2(NUM_PALAVRAS).
RESET_PC, 32'h0, PC value after reset and on every Iniciar.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
Start_Carga  in  1  pulse: enter load mode
Fim_Carga  in  1  pulse: end load; a partial word is flushed
Byte_Valido  in  1  loader byte valid
Byte_Dado  in  8  loader byte, little-endian within the word
Byte_Pronto  out  1  controller accepts a byte
Iniciar  in  1  pulse: start execution at RESET_PC
Stall  in  1  hold PC
Desvio  in  1  branch/jump taken
Alvo_Desvio  in  32  branch target byte address
Instrucao_In  in  32  read data from instruction memory
Mem_Endereco  out  ADDR_W  memory word index
Mem_Escrita  out  1  memory write strobe
Mem_Dado  out  32  memory write data
PC  out  32  current PC byte address
Instrucao_Valida  out  1  Instrucao_In is a valid fetch this cycle
Executando  out  1  high in EXECUTA
Palavras_Carregadas  out  ADDR_W+1  words written in the last load
Erro_Alinhamento  out  1  sticky misaligned-branch flag

Behaviour:
- Reset (async, any state, including mid-load): state IDLE, PC=RESET_PC, all strobes and flags 0, Palavras_Carregadas=0, byte lane=0. A partial word is discarded. Memory contents are untouched.
- States: IDLE, CARGA, EXECUTA, PARADO.
- Start_Carga has priority over Iniciar in every state. Start_Carga takes the block to CARGA, clears the load pointer, lane, Palavras_Carregadas and Erro_Alinhamento.
- IDLE/PARADO: Iniciar goes to EXECUTA with PC=RESET_PC and clears Erro_Alinhamento. Mem_Endereco=PC[ADDR_W+1:2].
- CARGA:
  - Byte_Pronto=1 except in a write cycle.
  - On a Byte_Valido&&Byte_Pronto transfer, the byte goes into lane 0..3 (first byte is bits[7:0]).
  - After lane 3, the next cycle is a write cycle: Mem_Escrita=1 for exactly one cycle, Mem_Endereco=pointer, Mem_Dado=assembled word, Byte_Pronto=0. The pointer and Palavras_Carregadas then increment.
  - Fim_Carga with 1-3 lanes filled produces one zero-padded write cycle, then IDLE. Fim_Carga with 0 lanes goes to IDLE next cycle.
  - If Fim_Carga and a byte transfer coincide, the byte is accepted first, then the flush.
  - After the write at index NUM_PALAVRAS-1, the block goes to IDLE. Palavras_Carregadas=NUM_PALAVRAS. Excess bytes are never accepted because Byte_Pronto=0.
- EXECUTA:
  - Executando=1. Mem_Escrita=0. Mem_Endereco=PC[ADDR_W+1:2], combinational read, same cycle.
  - Instrucao_Valida=!Stall.
  - PC update priority: Stall holds PC, and Desvio is ignored. Otherwise Desvio loads Alvo_Desvio. Otherwise PC+4.
  - PC is kept modulo NUM_PALAVRAS*4: it wraps from 0x3FC to 0x000 and bits above ADDR_W+1 of Alvo_Desvio are dropped.
  - Desvio with Alvo_Desvio[1:0]!=0 sets Erro_Alinhamento, goes to PARADO, and leaves PC unchanged.
- Output reset values: Byte_Pronto=0, Mem_Escrita=0, Mem_Dado=0, Instrucao_Valida=0, Executando=0, Erro_Alinhamento=0.

Optional Feature:
HALT_ON_ECALL_EN:
- Defined: when Instrucao_Valida and Instrucao_In==32'h00000073 (ecall) or 32'h00100073 (ebreak), the block goes to PARADO next cycle. PC holds the ecall address. Instrucao_Valida=0 from then on.
- Undefined: these encodings are fetched like any other instruction.

Test Plan:
- Load: Start_Carga, then bytes 93,03,B0,00 (addi x7,x0,11), then Fim_Carga -> one Mem_Escrita at index 0 with Mem_Dado=32'h00B00393, Palavras_Carregadas=1, state IDLE.
- Partial flush: bytes 11,22, then Fim_Carga -> write index 0, data 32'h00002211, then IDLE. Reset after byte 11 alone -> no write, Palavras_Carregadas=0.
- Run: Iniciar, 5 cycles without stall -> PC 0,4,8,C,10. Stall for 2 cycles at PC=8 -> PC holds, Instrucao_Valida=0. Desvio with target 0x3FC, then next cycle -> PC=0x3FC, then 0x000.
- Misaligned: Desvio with Alvo_Desvio=0x22 -> Erro_Alinhamento=1, PARADO, PC unchanged. Iniciar -> PC=0, flag cleared.
- Full memory: 1024 bytes streamed with Byte_Valido held high -> 256 writes, Palavras_Carregadas=256, Byte_Pronto=0 afterwards. Start_Carga and Iniciar in the same cycle -> CARGA.
- With HALT_ON_ECALL_EN: word 2 = 32'h00000073 -> PC stops at 0x8, PARADO, Executando=0. Without the macro -> PC advances to 0xC.
